// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller for the 5-stage core: EX operand forward
// selects, load-use stalls, taken-branch flushes and memory-wait freezes.
module hazard_forward_ctrl #(
  parameter int unsigned RW = 5,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  input  logic          id_use_rs1,
  input  logic          id_use_rs2,
  input  logic [RW-1:0] id_rd,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          ex_branch_taken,
  input  logic          mem_busy,
  output logic [1:0]    fwd_a_sel,
  output logic [1:0]    fwd_b_sel,
  output logic          hold_if_id,
  output logic          bubble_ex,
  output logic          flush_if_id,
  output logic          freeze,
  output logic [CW-1:0] stall_cnt
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_EX  = 2'b10;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rd;
    logic          reg_write;
    logic          mem_read;
  } shadow_t;

  typedef enum logic {RUN, LU_STALL} state_t;

  state_t        state_q, state_d;
  shadow_t       exs_q, exs_d;
  shadow_t       mems_q, mems_d;
  logic [1:0]    fwd_a_q, fwd_a_d;
  logic [1:0]    fwd_b_q, fwd_b_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;

  logic    a_hit_ex, a_hit_mem, b_hit_ex, b_hit_mem, lu_hit;
  logic [1:0] a_sel_nxt, b_sel_nxt;
  shadow_t id_entry;

  // Source candidacy against the in-flight shadows
  always_comb begin
    a_hit_ex  = id_valid && id_use_rs1 && (id_rs1 != '0) && exs_q.valid
                && exs_q.reg_write && (id_rs1 == exs_q.rd);
    a_hit_mem = id_valid && id_use_rs1 && (id_rs1 != '0) && mems_q.valid
                && mems_q.reg_write && (id_rs1 == mems_q.rd);
    b_hit_ex  = id_valid && id_use_rs2 && (id_rs2 != '0) && exs_q.valid
                && exs_q.reg_write && (id_rs2 == exs_q.rd);
    b_hit_mem = id_valid && id_use_rs2 && (id_rs2 != '0) && mems_q.valid
                && mems_q.reg_write && (id_rs2 == mems_q.rd);
    a_sel_nxt = a_hit_ex ? SEL_EX : (a_hit_mem ? SEL_MEM : SEL_RF);
    b_sel_nxt = b_hit_ex ? SEL_EX : (b_hit_mem ? SEL_MEM : SEL_RF);
    lu_hit    = exs_q.mem_read && (a_hit_ex || b_hit_ex);
    id_entry.valid     = id_valid;
    id_entry.rd        = id_rd;
    id_entry.reg_write = id_valid && id_reg_write;
    id_entry.mem_read  = id_valid && id_mem_read;
  end

  // Next-state and pipeline control; priority freeze > branch > load-use > normal
  always_comb begin
    state_d     = state_q;
    exs_d       = exs_q;
    mems_d      = mems_q;
    fwd_a_d     = fwd_a_q;
    fwd_b_d     = fwd_b_q;
    stall_cnt_d = stall_cnt_q;
    hold_if_id  = 1'b0;
    bubble_ex   = 1'b0;
    flush_if_id = 1'b0;
    freeze      = 1'b0;
    if (!reset) begin
      if (mem_busy) begin
        freeze = 1'b1;
      end else begin
        mems_d  = exs_q;
        state_d = RUN;
        if (ex_branch_taken) begin
          flush_if_id = 1'b1;
          bubble_ex   = 1'b1;
          exs_d       = '0;
          fwd_a_d     = SEL_RF;
          fwd_b_d     = SEL_RF;
        end else if ((state_q == RUN) && lu_hit) begin
          hold_if_id = 1'b1;
          bubble_ex  = 1'b1;
          exs_d      = '0;
          fwd_a_d    = SEL_RF;
          fwd_b_d    = SEL_RF;
          state_d    = LU_STALL;
        end else begin
          exs_d   = id_entry;
          fwd_a_d = a_sel_nxt;
          fwd_b_d = b_sel_nxt;
        end
      end
      if ((hold_if_id || freeze) && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      exs_q       <= '0;
      mems_q      <= '0;
      fwd_a_q     <= SEL_RF;
      fwd_b_q     <= SEL_RF;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      exs_q       <= exs_d;
      mems_q      <= mems_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Table-driven bench for hazard_forward_ctrl; registered results go through a
// scoreboard queue and are compared one edge after each vector is driven.
module tb_hazard_forward_ctrl;

  localparam int unsigned RW = 5;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
  logic          ex_branch_taken, mem_busy;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          hold_if_id, bubble_ex, flush_if_id, freeze;
  logic [CW-1:0] stall_cnt;

  hazard_forward_ctrl #(.RW(RW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .hold_if_id(hold_if_id), .bubble_ex(bubble_ex),
    .flush_if_id(flush_if_id), .freeze(freeze), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst, valid;
    logic [RW-1:0] rs1, rs2;
    logic          u1, u2;
    logic [RW-1:0] rd;
    logic          rw, mr, br, busy;
    logic [3:0]    ctl;   // {hold, bubble, flush, freeze} during the cycle
    logic [1:0]    ea, eb;
    logic [CW-1:0] ecnt;  // after the edge
  } vec_t;

  typedef struct {
    int            idx;
    logic [1:0]    ea, eb;
    logic [CW-1:0] ecnt;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t v(input logic rst, input logic valid,
                             input int rs1, input int rs2, input logic u1, input logic u2,
                             input int rd, input logic rw, input logic mr,
                             input logic br, input logic busy, input logic [3:0] ctl,
                             input logic [1:0] ea, input logic [1:0] eb, input int ecnt);
    vec_t r;
    r.rst = rst; r.valid = valid; r.rs1 = RW'(rs1); r.rs2 = RW'(rs2);
    r.u1 = u1; r.u2 = u2; r.rd = RW'(rd); r.rw = rw; r.mr = mr; r.br = br;
    r.busy = busy; r.ctl = ctl; r.ea = ea; r.eb = eb; r.ecnt = CW'(ecnt);
    return r;
  endfunction

  task automatic apply(input vec_t t, input int idx);
    exp_t e, got;
    logic [3:0] ctl;
    @(negedge clk);
    reset = t.rst; id_valid = t.valid; id_rs1 = t.rs1; id_rs2 = t.rs2;
    id_use_rs1 = t.u1; id_use_rs2 = t.u2; id_rd = t.rd; id_reg_write = t.rw;
    id_mem_read = t.mr; ex_branch_taken = t.br; mem_busy = t.busy;
    #1;
    ctl = {hold_if_id, bubble_ex, flush_if_id, freeze};
    checks++;
    if (ctl !== t.ctl) begin
      errors++;
      $display("FAIL ctl[%0d] hold/bubble/flush/freeze got %b want %b", idx, ctl, t.ctl);
    end
    e.idx = idx; e.ea = t.ea; e.eb = t.eb; e.ecnt = t.ecnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    checks++;
    if (fwd_a_sel !== got.ea) begin
      errors++;
      $display("FAIL fwd_a[%0d] got %b want %b", got.idx, fwd_a_sel, got.ea);
    end
    checks++;
    if (fwd_b_sel !== got.eb) begin
      errors++;
      $display("FAIL fwd_b[%0d] got %b want %b", got.idx, fwd_b_sel, got.eb);
    end
    checks++;
    if (stall_cnt !== got.ecnt) begin
      errors++;
      $display("FAIL stall_cnt[%0d] got %0d want %0d", got.idx, stall_cnt, got.ecnt);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_reg_write = 1'b0;
    id_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b0;

    //                rst vl rs1 rs2 u1 u2 rd rw mr br bz  ctl     ea     eb   cnt
    // forwarding: back-to-back, one gap, priority, use bits, x0, invalid, no-write
    tbl.push_back(v(1, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0));
    tbl.push_back(v(0, 1,  1,  2, 1, 1,  5, 1, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0));
    tbl.push_back(v(0, 1,  5,  6, 1, 1,  8, 1, 0, 0, 0, 4'b0000, 2'b10, 2'b00, 0));
    tbl.push_back(v(0, 1,  1,  2, 1, 1,  5, 1, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0));
    tbl.push_back(v(0, 1,  3,  4, 1, 1, 10, 1, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0));
    tbl.push_back(v(0, 1,  1,  5, 1, 1, 11, 1, 0, 0, 0, 4'b0000, 2'b00, 2'b01, 0));
    tbl.push_back(v(0, 1,  1,  2, 1, 1,  5, 1, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0));
    tbl.push_back(v(0, 1,  3,  4, 1, 1,  5, 1, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0));
    tbl.push_back(v(0, 1,  5,  5, 1, 1, 12, 1, 0, 0, 0, 4'b0000, 2'b10, 2'b10, 0));
    tbl.push_back(v(0, 1, 12, 12, 0, 1, 13, 1, 0, 0, 0, 4'b0000, 2'b00, 2'b10, 0));
    tbl.push_back(v(0, 1,  1,  2, 1, 1,  0, 1, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0));
    tbl.push_back(v(0, 1,  0,  0, 1, 1, 14, 1, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0));
    tbl.push_back(v(0, 0, 14, 14, 1, 1,  0, 0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0));
    tbl.push_back(v(0, 1,  1,  2, 1, 1, 15, 0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0));
    tbl.push_back(v(0, 1, 15, 14, 1, 1, 16, 1, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0));
    // load-use: one-cycle stall, then MEM forward on re-evaluation
    tbl.push_back(v(1, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0));
    tbl.push_back(v(0, 1,  1,  0, 1, 0,  7, 1, 1, 0, 0, 4'b0000, 2'b00, 2'b00, 0));
    tbl.push_back(v(0, 1,  7,  3, 1, 1,  8, 1, 0, 0, 0, 4'b1100, 2'b00, 2'b00, 1));
    tbl.push_back(v(0, 1,  7,  3, 1, 1,  8, 1, 0, 0, 0, 4'b0000, 2'b01, 2'b00, 1));
    tbl.push_back(v(0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 1));
    // branch overrides load-use
    tbl.push_back(v(1, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0));
    tbl.push_back(v(0, 1,  1,  0, 1, 0,  7, 1, 1, 0, 0, 4'b0000, 2'b00, 2'b00, 0));
    tbl.push_back(v(0, 1,  7,  3, 1, 1,  8, 1, 0, 1, 0, 4'b0110, 2'b00, 2'b00, 0));
    tbl.push_back(v(0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0));
    // freeze for 3 cycles during load-use, selects held, then the stall
    tbl.push_back(v(1, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0));
    tbl.push_back(v(0, 1,  1,  2, 1, 1,  3, 1, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0));
    tbl.push_back(v(0, 1,  3,  0, 1, 0,  7, 1, 1, 0, 0, 4'b0000, 2'b10, 2'b00, 0));
    tbl.push_back(v(0, 1,  7,  3, 1, 1,  8, 1, 0, 0, 1, 4'b0001, 2'b10, 2'b00, 1));
    tbl.push_back(v(0, 1,  7,  3, 1, 1,  8, 1, 0, 0, 1, 4'b0001, 2'b10, 2'b00, 2));
    tbl.push_back(v(0, 1,  7,  3, 1, 1,  8, 1, 0, 0, 1, 4'b0001, 2'b10, 2'b00, 3));
    tbl.push_back(v(0, 1,  7,  3, 1, 1,  8, 1, 0, 0, 0, 4'b1100, 2'b00, 2'b00, 4));
    tbl.push_back(v(0, 1,  7,  3, 1, 1,  8, 1, 0, 0, 0, 4'b0000, 2'b01, 2'b00, 4));
    // reset while in LU_STALL
    tbl.push_back(v(1, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0));
    tbl.push_back(v(0, 1,  1,  0, 1, 0,  7, 1, 1, 0, 0, 4'b0000, 2'b00, 2'b00, 0));
    tbl.push_back(v(0, 1,  7,  3, 1, 1,  8, 1, 0, 0, 0, 4'b1100, 2'b00, 2'b00, 1));
    tbl.push_back(v(1, 1,  7,  3, 1, 1,  8, 1, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0));
    tbl.push_back(v(0, 1,  7,  3, 1, 1,  8, 1, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0));

    foreach (tbl[i]) apply(tbl[i], i);

    // reset asserted mid-freeze clears state and the counter
    apply(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0), 100);
    apply(v(0, 1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 4'b0000, 2'b00, 2'b00, 0), 101);
    apply(v(0, 1, 7, 3, 1, 1, 8, 1, 0, 0, 1, 4'b0001, 2'b00, 2'b00, 1), 102);
    apply(v(1, 1, 7, 3, 1, 1, 8, 1, 0, 0, 1, 4'b0000, 2'b00, 2'b00, 0), 103);
    apply(v(0, 1, 7, 3, 1, 1, 8, 1, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0), 104);

    // counter saturation at 2^CW-1
    for (int k = 0; k < 10; k++) begin
      apply(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0001, 2'b00, 2'b00,
              (k + 1 > 7) ? 7 : k + 1), 200 + k);
    end
    apply(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 7), 210);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
